// File: rtl/mnist_bram_pkg.sv
// Shared types and constants for the MNIST BRAM port-B stream reader.
// State codes, width defaults and the done-flag word layout.
package mnist_bram_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [9:0] FLAG_ADDR_DEF = 10'h3FF;
  localparam int FLAG_BIT   = 31;
  localparam int FLAG_CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_FLAG  = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  function automatic logic [31:0] flag_word(
    input logic [FLAG_CNT_W-1:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[FLAG_BIT] = 1'b1;
    w[FLAG_CNT_W-1:0] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/bram_portb_stream_reader_fifo.sv
// Small synchronous skid FIFO with occupancy count.
// Head word is presented combinationally and held until popped.
module sync_fifo_skid #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rdata,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_portb_stream_reader.sv
// Port-B BRAM reader streaming word_count words to an AXI-Stream master.
// Define BRAM_DONE_FLAG_WRITEBACK_EN to write a done flag word at FLAG_ADDR.
module bram_portb_stream_reader
  import mnist_bram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(FLAG_ADDR_DEF)
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] BRAM_PORTB_addr,
  output logic [DATA_W-1:0] BRAM_PORTB_din,
  input  logic [DATA_W-1:0] BRAM_PORTB_dout,
  output logic              BRAM_PORTB_en,
  output logic              BRAM_PORTB_rst,
  output logic [3:0]        BRAM_PORTB_we,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW   = FCW + 1;

`ifdef BRAM_DONE_FLAG_WRITEBACK_EN
  localparam state_t S_TAIL = S_FLAG;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    issued;
  logic [CNT_W-1:0]    emitted;
  logic [READ_LAT-1:0] tag;
  logic [CRW-1:0]      inflight;
  logic [FCW-1:0]      fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   head;
  logic                push;
  logic                pop;
  logic                rd_en;
  logic                last_issue;
  logic                drained;
  logic                flag_wr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight = inflight + CRW'(tag[i]);
    end
  end

  // Credits count words held or still in the BRAM pipe, so a
  // stalled sink can never cause the FIFO to overflow.
  assign rd_en = (state == S_ISSUE) &&
    ((CRW'(fifo_count) + inflight) < CRW'(FIFO_DEPTH));

  assign last_issue = rd_en && ((issued + CNT_W'(1)) == count_q);
  assign push       = tag[READ_LAT-1];
  assign pop        = !fifo_empty && m_axis_tready;
  assign drained    = (emitted == count_q) && fifo_empty &&
                      (inflight == '0);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state   <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      issued  <= '0;
      emitted <= '0;
      tag     <= '0;
    end else begin
      tag[0] <= rd_en;
      for (int i = 1; i < READ_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
      if (pop) emitted <= emitted + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            issued  <= '0;
            emitted <= '0;
            state   <= (word_count == '0) ? S_TAIL : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rd_en) issued <= issued + CNT_W'(1);
          if (last_issue) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drained) state <= S_TAIL;
        end
`ifdef BRAM_DONE_FLAG_WRITEBACK_EN
        S_FLAG: state <= S_DONE;
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      assert (!(push && fifo_full && !pop));
    end
  end

  sync_fifo_skid #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .push  (push),
    .wdata (BRAM_PORTB_dout),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef BRAM_DONE_FLAG_WRITEBACK_EN
  assign flag_wr = (state == S_FLAG);
  assign BRAM_PORTB_we  = flag_wr ? 4'hF : 4'h0;
  assign BRAM_PORTB_din = flag_wr ?
    DATA_W'(flag_word(FLAG_CNT_W'(count_q))) : '0;
`else
  logic unused_flag_addr;
  assign unused_flag_addr = ^FLAG_ADDR;
  assign flag_wr        = 1'b0;
  assign BRAM_PORTB_we  = 4'h0;
  assign BRAM_PORTB_din = '0;
`endif

  assign BRAM_PORTB_en   = rd_en | flag_wr;
  assign BRAM_PORTB_rst  = 1'b0;
  assign BRAM_PORTB_addr = flag_wr ? FLAG_ADDR :
    (rd_en ? base_q + issued[ADDR_W-1:0] : '0);

  assign busy = (state == S_ISSUE) || (state == S_DRAIN) ||
                (state == S_FLAG);
  assign done = (state == S_DONE);

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head;
  assign m_axis_tlast  = !fifo_empty &&
                         (emitted == (count_q - CNT_W'(1)));

endmodule

// File: tb/tb_bram_portb_stream_reader.sv
// Directed plus randomized bench for bram_portb_stream_reader.
// Expected streams are taken from a BRAM snapshot taken before each run.
module tb_bram_portb_stream_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        busy;
  logic        done;
  logic [9:0]  b_addr;
  logic [31:0] b_din;
  logic [31:0] b_dout;
  logic        b_en;
  logic        b_rst;
  logic [3:0]  b_we;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  always #5 clk = ~clk;

  bram_portb_stream_reader #(
    .ADDR_W     (10),
    .DATA_W     (32),
    .READ_LAT   (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .s_axi_aclk      (clk),
    .s_axi_aresetn   (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .BRAM_PORTB_addr (b_addr),
    .BRAM_PORTB_din  (b_din),
    .BRAM_PORTB_dout (b_dout),
    .BRAM_PORTB_en   (b_en),
    .BRAM_PORTB_rst  (b_rst),
    .BRAM_PORTB_we   (b_we),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .m_axis_tlast    (tlast)
  );

  logic [31:0] mem [1024];

  // Read-first BRAM port with one cycle of read latency
  always @(posedge clk) begin
    if (b_en) begin
      b_dout <= mem[b_addr];
      for (int k = 0; k < 4; k++) begin
        if (b_we[k]) mem[b_addr][8*k +: 8] = b_din[8*k +: 8];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] bq_data [$];
  bit          bq_last [$];
  int          bq_cyc  [$];
  int          aq      [$];
  logic [31:0] exp_q   [$];
  int          issued_n, accepted_n, credit_err, stab_err;
  int          en_cnt, we_cnt, tvalid_cnt, done_cnt, done_cyc;
  logic [31:0] flag_at_done;
  bit          prev_hold;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_en && b_we == 4'h0) begin
        if (issued_n - accepted_n >= DEPTH) credit_err++;
        issued_n++;
        en_cnt++;
        aq.push_back(int'(b_addr));
      end
      if (b_we != 4'h0) we_cnt++;
      if (tvalid) tvalid_cnt++;
      if (prev_hold && (!tvalid || tdata !== prev_data ||
                        tlast !== prev_last)) stab_err++;
      prev_hold = tvalid && !tready;
      prev_data = tdata;
      prev_last = tlast;
      if (tvalid && tready) begin
        bq_data.push_back(tdata);
        bq_last.push_back(tlast);
        bq_cyc.push_back(cyc);
        accepted_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        flag_at_done = mem[10'h3FF];
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    bq_data.delete();
    bq_last.delete();
    bq_cyc.delete();
    aq.delete();
    issued_n = 0; accepted_n = 0; credit_err = 0; stab_err = 0;
    en_cnt = 0; we_cnt = 0; tvalid_cnt = 0; done_cnt = 0;
    done_cyc = -1; prev_hold = 1'b0;
  endtask

  function automatic logic next_ready(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return !tready;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input int b, input int n, input int mode,
                     input int extra_at, output int s);
    int k;
    clear();
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 1024]);
    @(posedge clk); #1;
    base_addr = 10'(b);
    word_count = 11'(n);
    start = 1'b1;
    tready = 1'b1;
    s = cyc;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == extra_at) begin
        start = 1'b1;
        base_addr = 10'h200;
        word_count = 11'd5;
      end
      tready = next_ready(mode);
      k++;
    end
    if (k >= 3000) chk("timeout", 0, 1);
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'b0;
      tready = 1'b1;
    end
  endtask

  task automatic verify(input string name, input int n);
    int derr, lerr;
    derr = 0;
    lerr = 0;
    chk({name, "_beats"}, bq_data.size(), n);
    for (int i = 0; i < bq_data.size() && i < n; i++) begin
      if (bq_data[i] !== exp_q[i]) derr++;
      if (bq_last[i] !== (i == n - 1)) lerr++;
    end
    chk({name, "_data"}, derr, 0);
    chk({name, "_tlast"}, lerr, 0);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_credit"}, credit_err, 0);
    chk({name, "_stable"}, stab_err, 0);
    chk({name, "_reads"}, en_cnt, n);
  endtask

  initial begin
    int s, aerr, nb, rb, rn;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    tready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {26'd0, busy, done, b_en, tvalid, tlast, b_rst}, 0);
    chk("rst_we", b_we, 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_din", b_din, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 8-word run with sink always ready
    for (int i = 0; i < 8; i++) mem[16 + i] = 32'hA0 + i;
    mem[10'h3FF] = 32'hDEADBEEF;
    run(16, 8, 0, -1, s);
    verify("basic", 8);
    nb = bq_cyc.size();
    chk("latency", (nb > 0) ? bq_cyc[0] - s : -1, 3);
    chk("back2back", (nb == 8) ? bq_cyc[7] - bq_cyc[0] : -1, 7);
`ifdef BRAM_DONE_FLAG_WRITEBACK_EN
    chk("flag_word", flag_at_done, 32'h80000008);
`else
    chk("flag_untouched", mem[10'h3FF], 32'hDEADBEEF);
    chk("we_zero", we_cnt, 0);
`endif

    run(16, 8, 1, -1, s);
    verify("toggle", 8);

    // Address wrap from the top of memory
    mem[10'h3FE] = 1; mem[10'h3FF] = 2; mem[0] = 3; mem[1] = 4;
    run(10'h3FE, 4, 0, -1, s);
    verify("wrap", 4);
    aerr = 0;
    for (int i = 0; i < aq.size(); i++) begin
      if (aq[i] != (16'h3FE + i) % 1024) aerr++;
    end
    chk("wrap_addr", aerr, 0);

    run(32, 0, 0, -1, s);
    chk("zero_beats", bq_data.size(), 0);
    chk("zero_reads", en_cnt, 0);
    chk("zero_tvalid", tvalid_cnt, 0);
    chk("zero_done", done_cnt, 1);
`ifndef BRAM_DONE_FLAG_WRITEBACK_EN
    chk("zero_done_cyc", done_cyc - s, 1);
`endif

    run(256, 16, 0, 3, s);
    verify("restart_ignored", 16);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      rb = $urandom_range(0, 1023);
      rn = $urandom_range(1, 40);
      run(rb, rn, 2, -1, s);
      verify("random", rn);
    end

    rb = $urandom_range(0, 1023);
    run(rb, 1024, 0, -1, s);
    verify("full_mem", 1024);

    // Reset in the middle of a 10-word transfer
    clear();
    @(posedge clk); #1;
    base_addr = 10'h040;
    word_count = 11'd10;
    start = 1'b1;
    tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    while (bq_data.size() < 3 && nb < 50) begin
      @(posedge clk); #1;
      nb++;
    end
    if (nb >= 50) chk("mid_timeout", 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ctl", {27'd0, busy, done, b_en, tvalid, tlast}, 0);
    chk("mid_rst_bus", {b_addr, b_we}, 0);
    chk("mid_rst_tdata", tdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(80, 2, 0, -1, s);
    verify("post_reset", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_portb_stream_reader.md
Name: bram_portb_stream_reader

Overview:
- PL-side consumer on port B of the PS-shared dual-port BRAM.
- The PS fills the BRAM over AXI-Lite through port A, then pulses `start`. This block reads `word_count` 32-bit words from `base_addr` on port B.
- Words leave on an AXI-Stream-style master interface (valid/ready, last) to the MNIST datapath.
- A credit-controlled FIFO absorbs the BRAM read latency so backpressure never loses data.

Parameters:
- ADDR_W, 10, port B word-address width (1024 x 32 memory).
- DATA_W, 32, BRAM/stream data width.
- READ_LAT, 1, BRAM port B read latency in cycles (1 or 2; 2 when the output register is enabled).
- FIFO_DEPTH, 4, skid FIFO entries; power of two, must be >= READ_LAT+2.
- FLAG_ADDR, 10'h3FF, word address written by the optional done-flag writeback.

Ports:
- s_axi_aclk  in  1  clock, shared with the BRAM controller.
- s_axi_aresetn  in  1  synchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- word_count  in  ADDR_W+1  words to read, 0..1024; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- BRAM_PORTB_addr  out  ADDR_W  word address.
- BRAM_PORTB_din  out  DATA_W  write data; 0 except during flag writeback.
- BRAM_PORTB_dout  in  DATA_W  read data, valid READ_LAT cycles after en.
- BRAM_PORTB_en  out  1  port enable, one cycle per access.
- BRAM_PORTB_rst  out  1  tied 0.
- BRAM_PORTB_we  out  4  byte write enables; 0 except during flag writeback.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final word.

Behaviour:
- Reset (s_axi_aresetn=0 at a clock edge) clears:
  - all outputs to 0;
  - FSM to IDLE;
  - FIFO pointers, in-flight counter, issue/emit counters.
- Reset mid-transfer abandons the transfer. Late BRAM returns are discarded because the in-flight pipe is cleared.
- FSM states: IDLE, ISSUE, DRAIN, FLAG, DONE.
- IDLE:
  - start=1 latches base_addr and word_count and asserts busy next cycle.
  - word_count=0 goes straight to DONE (or FLAG, see option); no reads are issued.
  - Otherwise go to ISSUE.
  - start while not in IDLE is ignored.
- ISSUE:
  - Issue a read (en=1, we=0, addr=base+issued) only when fifo_count + inflight < FIFO_DEPTH.
  - Address arithmetic wraps modulo 2^ADDR_W (0x3FF+1 -> 0x000).
  - After the last issue, go to DRAIN.
- In-flight tracking: a READ_LAT-deep valid shift register tags issued reads.
  - Data is pushed into the FIFO the cycle the tag emerges.
  - The credit rule guarantees the FIFO never overflows. A push to a full FIFO is a design error and is asserted in simulation.
- Stream output:
  - m_axis_tvalid = FIFO not empty; tdata = FIFO head.
  - A transfer occurs when tvalid&tready. Once asserted, tvalid/tdata stay stable until accepted.
  - tlast=1 on word index word_count-1.
  - A simultaneous push and pop keeps the count unchanged.
- Throughput: one word/cycle with tready held high.
- First-word latency: start cycle + 1 (ISSUE) + READ_LAT + 1 (FIFO register).
- DRAIN: wait until emitted==word_count and the FIFO and in-flight pipe are empty, then go to FLAG (option) or DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.

Optional Feature:
- Macro: `BRAM_DONE_FLAG_WRITEBACK_EN`.
- When defined, FLAG state performs one write cycle: en=1, we=4'hF, addr=FLAG_ADDR, din={1'b1, 15'b0, word_count zero-extended to 16 bits}. This lets the PS poll completion over AXI-Lite; it then takes DONE next cycle.
- When undefined, FLAG state does not exist, we is constant 0, din is constant 0, and DRAIN goes directly to DONE.

Decomposition:
- Shared package `mnist_bram_pkg`:
  - state enum;
  - ADDR_W/DATA_W defaults;
  - FLAG_ADDR;
  - done-flag word layout constants.
- One sub-module, `sync_fifo_skid` (parameters DATA_W, FIFO_DEPTH), with:
  - push/pop;
  - count output;
  - full/empty;
  - synchronous active-low reset.

Test Plan:
- Preload BRAM[0x010..0x017]=0xA0..0xA7; base=0x010, count=8, tready=1 -> 8 beats on consecutive cycles, data 0xA0..0xA7, tlast only on 0xA7, one done pulse.
- Same preload, tready toggling 1/0 per cycle -> no loss or duplication, data order preserved, en never issued when fifo_count+inflight=4.
- base=0x3FE, count=4, BRAM[0x3FE]=1, [0x3FF]=2, [0x000]=3, [0x001]=4 -> stream 1,2,3,4 with addresses 3FE,3FF,000,001.
- count=0 -> no en pulses, no tvalid, done one cycle after start; a second start during busy of a count=16 run is ignored (16 beats total).
- Reset asserted mid-transfer after 3 of 10 beats -> all outputs 0 next cycle; a new start with count=2 streams exactly 2 correct words.
- With `BRAM_DONE_FLAG_WRITEBACK_EN`: count=8 -> BRAM[0x3FF]=0x80000008 before done. Without the macro, BRAM[0x3FF] is unchanged and we is never nonzero.
